// File: rtl/sc_disp_pkg.sv
// ============================================================================
// Module : sc_disp_pkg
// Brief  : Shared segment codes, FSM state type and BCD sizing for sc_port_display.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sc_disp_pkg;

    // Active-low segment patterns, bit order g..a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        UPDATE = 2'd3
    } state_t;

    // Decimal digits needed for 2^data_w-1: floor(data_w*log10(2))+1
    function automatic int bcd_digits(input int data_w);
        return (data_w * 30103) / 100000 + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sc_seg7_decode.sv
// ============================================================================
// Module : sc_seg7_decode
// Brief  : Combinational BCD digit to active-low seven-segment pattern.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sc_seg7_decode
    import sc_disp_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sc_port_display.sv
// ============================================================================
// Module : sc_port_display
// Brief  : Sequential double-dabble binary-to-decimal converter driving
//          DIGITS active-low seven-segment displays. Optional macro
//          SC_DISP_LZB_EN enables leading-zero blanking.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sc_port_display
    import sc_disp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIGITS = 6
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [DATA_W-1:0]     value,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  busy,
    output logic                  done
);

    localparam int C_BCD_N = (bcd_digits(DATA_W) > DIGITS) ? bcd_digits(DATA_W) : DIGITS;
    localparam int C_BCD_W = 4 * C_BCD_N;
    localparam int C_CNT_W = $clog2(DATA_W + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DATA_W - 1);

    state_t                       r_state;
    state_t                       w_next;
    logic [DATA_W-1:0]            r_last;
    logic                         r_first;
    logic [DATA_W-1:0]            r_shreg;
    logic [C_BCD_W-1:0]           r_bcd;
    logic [C_CNT_W-1:0]           r_cnt;
    logic                         r_busy;
    logic                         r_done;
    logic [7*DIGITS-1:0]          r_hex;

    logic [C_BCD_W-1:0]           w_adj;
    logic [C_BCD_W+DATA_W-1:0]    w_shift;
    logic [7*DIGITS-1:0]          w_seg;
    logic [7*DIGITS-1:0]          w_disp;
    logic                         w_ovf;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_first || (value != r_last)) w_next = LOAD;
            LOAD:    w_next = SHIFT;
            SHIFT:   if (r_cnt == C_CNT_LAST) w_next = UPDATE;
            UPDATE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Add-3 correction on every nibble before each shift
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < C_BCD_N; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    assign w_shift = {w_adj, r_shreg} << 1;

    always_comb begin
        w_ovf = 1'b0;
        for (int i = DIGITS; i < C_BCD_N; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) w_ovf = 1'b1;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        sc_seg7_decode u_dec (
            .i_bcd (r_bcd[4*k +: 4]),
            .o_seg (w_seg[7*k +: 7])
        );
    end

`ifdef SC_DISP_LZB_EN
    logic w_lead;
    // Digit 0 is never blanked so zero still shows a single "0"
    always_comb begin
        w_disp = w_seg;
        w_lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (r_bcd[4*k +: 4] != 4'd0) w_lead = 1'b0;
            if (w_lead) w_disp[7*k +: 7] = SEG_BLANK;
        end
    end
`else
    assign w_disp = w_seg;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_last  <= '0;
            r_first <= 1'b1;
            r_shreg <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hex   <= '1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                LOAD: begin
                    r_last  <= value;
                    r_shreg <= value;
                    r_bcd   <= '0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_first <= 1'b0;
                end
                SHIFT: begin
                    {r_bcd, r_shreg} <= w_shift;
                    r_cnt            <= r_cnt + 1'b1;
                end
                UPDATE: begin
                    r_hex  <= w_ovf ? {DIGITS{SEG_DASH}} : w_disp;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign hex  = r_hex;
    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire
